// File: rtl/univ_shift_register.sv
// univ_shift_register
//   Parametrised universal register. HOLD/LOAD/CLR complete in a single edge.
//   Shift and rotate ops move one bit per clock under a start/busy/done
//   handshake. Amounts above WIDTH are clamped to WIDTH.
//
//   Optional feature macro: PARITY_EN. When it is defined, a parity output
//   (XOR of q) is present.
//
// Ports
//   clk     rising-edge clock
//   reset   asynchronous reset, active low
//   d       parallel load data
//   op      000 HOLD, 001 LOAD, 010 SHL, 011 SHR, 100 ROL, 101 ROR, 110 ASR, 111 CLR
//   amt     shift amount (clamped to WIDTH)
//   start   command strobe, sampled only in IDLE
//   sin     serial fill for SHL/SHR, sampled live on every shift edge
//   q       register contents
//   busy    high while in SHIFT
//   done    one-cycle pulse after a command completes
//   sout    bit shifted out on the most recent shift
//   parity  ^q (PARITY_EN builds only)
module univ_shift_register #(
  parameter  int WIDTH = 7,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  input  logic [2:0]       op,
  input  logic [CNT_W-1:0] amt,
  input  logic             start,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             sout
`ifdef PARITY_EN
  ,output logic            parity
`endif
);

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_LOAD = 3'b001,
    OP_SHL  = 3'b010,
    OP_SHR  = 3'b011,
    OP_ROL  = 3'b100,
    OP_ROR  = 3'b101,
    OP_ASR  = 3'b110,
    OP_CLR  = 3'b111
  } op_e;

  typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_e;

  localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             sout_q, sout_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] n_amt;

  // One shift step. Returns {bit_out, new_q}.
  function automatic logic [WIDTH:0] shift1(input op_e o, input logic [WIDTH-1:0] v,
                                            input logic s);
    logic [WIDTH:0] r;
    case (o)
      OP_SHL:  r = {v[WIDTH-1], v[WIDTH-2:0], s};
      OP_SHR:  r = {v[0], s, v[WIDTH-1:1]};
      OP_ROL:  r = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
      OP_ROR:  r = {v[0], v[0], v[WIDTH-1:1]};
      OP_ASR:  r = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
      default: r = {1'b0, v};
    endcase
    return r;
  endfunction

  assign n_amt = (amt > WIDTH_C) ? WIDTH_C : amt;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rem_d   = rem_q;
    q_d     = q_q;
    sout_d  = sout_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (op_e'(op))
            OP_HOLD: done_d = 1'b1;
            OP_LOAD: begin q_d = d;  done_d = 1'b1; end
            OP_CLR:  begin q_d = '0; done_d = 1'b1; end
            default: begin
              // Latch the op so later edges ignore changes on the op input.
              op_d = op_e'(op);
              if (n_amt == '0) begin
                done_d = 1'b1;
              end else begin
                // First bit moves on the accepting edge itself.
                {sout_d, q_d} = shift1(op_e'(op), q_q, sin);
                rem_d         = n_amt - ONE_C;
                if (n_amt == ONE_C) done_d  = 1'b1;
                else                state_d = ST_SHIFT;
              end
            end
          endcase
        end
      end
      ST_SHIFT: begin
        {sout_d, q_d} = shift1(op_q, q_q, sin);
        rem_d         = rem_q - ONE_C;
        if (rem_q == ONE_C) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_HOLD;
      rem_q   <= '0;
      q_q     <= '0;
      sout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      sout_q  <= sout_d;
      done_q  <= done_d;
    end
  end

  assign q    = q_q;
  assign busy = (state_q == ST_SHIFT);
  assign done = done_q;
  assign sout = sout_q;

`ifdef PARITY_EN
  // q is forced to zero by reset, so parity reads 0 while reset is held.
  assign parity = ^q_q;
`endif

endmodule

// File: tb/tb_univ_shift_register.sv
module tb_univ_shift_register;
  localparam int W     = 7;
  localparam int CW    = $clog2(W + 1);
  localparam int MASK  = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  d;
  logic [2:0]    op;
  logic [CW-1:0] amt;
  logic          start;
  logic          sin;
  logic [W-1:0]  q;
  logic          busy, done, sout;
`ifdef PARITY_EN
  logic          parity;
`endif

  univ_shift_register #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .d(d), .op(op), .amt(amt), .start(start), .sin(sin),
    .q(q), .busy(busy), .done(done), .sout(sout)
`ifdef PARITY_EN
    , .parity(parity)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int mq = 0;   // reference register value
  int ms = 0;   // reference sout

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference shift, written as arithmetic on an integer.
  task automatic mshift(input int o, input int s);
    case (o)
      2: begin ms = (mq >> (W-1)) & 1; mq = ((mq << 1) | s) & MASK; end
      3: begin ms = mq & 1; mq = (mq >> 1) | (s << (W-1)); end
      4: begin ms = (mq >> (W-1)) & 1; mq = ((mq << 1) | ms) & MASK; end
      5: begin ms = mq & 1; mq = (mq >> 1) | (ms << (W-1)); end
      6: begin ms = mq & 1; mq = (mq >> 1) | (mq & (1 << (W-1))); end
      default: ;
    endcase
  endtask

  task automatic check_parity(input string nm);
`ifdef PARITY_EN
    check(nm, int'(parity), $countones(mq) % 2);
`else
    n_cmp = n_cmp;
`endif
  endtask

  // Issue one command; sm = 0/1 fixed sin, 2 = random sin every edge.
  task automatic run_cmd(input int o, input int dv, input int a, input int sm);
    int  n, remm, waited, busyc, ew;
    bit  is_sh;
    @(negedge clk);
    op = o[2:0]; d = dv[W-1:0]; amt = a[CW-1:0]; start = 1'b1;
    sin = (sm == 2) ? 1'($urandom_range(0, 1)) : 1'(sm);
    is_sh = (o >= 2) && (o <= 6);
    n = (a > W) ? W : a;
    if (o == 1)                mq = dv & MASK;
    else if (o == 7)           mq = 0;
    else if (is_sh && n > 0)   mshift(o, int'(sin));
    remm = (is_sh && n > 0) ? n - 1 : 0;
    ew = remm;
    @(posedge clk); #1 start = 1'b0;
    waited = 0; busyc = 0;
    @(negedge clk);
    while (!done && waited < 40) begin
      if (busy) busyc++;
      check("q_step", int'(q), mq);
      if (remm > 0) begin
        sin = (sm == 2) ? 1'($urandom_range(0, 1)) : 1'(sm);
        mshift(o, int'(sin));
        remm--;
      end
      waited++;
      @(negedge clk);
    end
    check("done_seen", int'(done), 1);
    check("latency", waited, ew);
    check("busy_cycles", busyc, ew);
    check("busy_at_done", int'(busy), 0);
    check("q_final", int'(q), mq);
    check("sout_final", int'(sout), ms);
    check_parity("parity_final");
    @(negedge clk);
    check("done_pulse", int'(done), 0);
  endtask

  typedef struct {
    int op; int d; int amt; int sn; int eq; int es;
  } vec_t;
  vec_t tbl[13];

  initial begin
    tbl[0]  = '{1, 7'b0101010, 0, 0, 7'b0101010, 0};
    tbl[1]  = '{2, 7'b0000000, 3, 1, 7'b1010111, 0};
    tbl[2]  = '{1, 7'b0101010, 0, 0, 7'b0101010, 0};
    tbl[3]  = '{5, 7'b0000000, 7, 0, 7'b0101010, 0};
    tbl[4]  = '{1, 7'b1000000, 0, 0, 7'b1000000, 0};
    tbl[5]  = '{6, 7'b0000000, 2, 0, 7'b1110000, 0};
    tbl[6]  = '{2, 7'b0000000, 0, 1, 7'b1110000, 0};
    tbl[7]  = '{7, 7'b1111111, 0, 0, 7'b0000000, 0};
    tbl[8]  = '{1, 7'b1011001, 0, 0, 7'b1011001, 0};
    tbl[9]  = '{3, 7'b0000000, 2, 0, 7'b0010110, 0};
    tbl[10] = '{4, 7'b0000000, 1, 0, 7'b0101100, 0};
    tbl[11] = '{0, 7'b1111111, 0, 0, 7'b0101100, 0};
    tbl[12] = '{6, 7'b0000000, 7, 0, 7'b0000000, 0};

    reset = 1'b0; d = 7'b0101010; op = 3'b000; amt = '0; start = 1'b0; sin = 1'b0;
    #12;
    check("rst_q", int'(q), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_sout", int'(sout), 0);
    check_parity("rst_parity");
    @(negedge clk); reset = 1'b1;

    for (int i = 0; i < 13; i++) begin
      run_cmd(tbl[i].op, tbl[i].d, tbl[i].amt, tbl[i].sn);
      check($sformatf("tbl%0d_q", i), int'(q), tbl[i].eq);
      check($sformatf("tbl%0d_sout", i), int'(sout), tbl[i].es);
    end

    // Start while busy is ignored; stepwise SHL values and sout.
    run_cmd(1, 7'b0101010, 0, 0);
    @(negedge clk); op = 3'b010; amt = 3; sin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("ign_busy1", int'(busy), 1);
    check("ign_q1", int'(q), 7'b1010101);
    check("ign_sout1", int'(sout), 0);
    op = 3'b001; d = 7'b1111111; start = 1'b1;
    @(negedge clk);
    check("ign_busy2", int'(busy), 1);
    check("ign_q2", int'(q), 7'b0101011);
    check("ign_sout2", int'(sout), 1);
    @(negedge clk);
    start = 1'b0;
    check("ign_done", int'(done), 1);
    check("ign_q3", int'(q), 7'b1010111);
    check("ign_sout3", int'(sout), 0);
    @(negedge clk);
    check("ign_done_low", int'(done), 0);
    check("ign_q_kept", int'(q), 7'b1010111);
    mq = 7'b1010111; ms = 0;

    // Asynchronous reset in the middle of a rotate.
    @(negedge clk); op = 3'b100; amt = 7; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk); @(negedge clk);
    check("mid_busy_pre", int'(busy), 1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_q", int'(q), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_sout", int'(sout), 0);
    check("mid_rst_done", int'(done), 0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    check("post_rst_busy", int'(busy), 0);
    check("post_rst_q", int'(q), 0);
    mq = 0; ms = 0;

    // Randomised commands against the reference model.
    for (int k = 0; k < 60; k++)
      run_cmd(int'($urandom_range(0, 7)), int'($urandom_range(0, MASK)),
              int'($urandom_range(0, (1 << CW) - 1)), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
